conv_window_sched: RTL
======================

# conv_window_sched

Sequencer for one 3x3 convolution layer pass over a stored feature map. Walks every valid output position in raster order and, for each position, loads base addresses into the window address generator. It then enables the generator for exactly K*K cycles and gates the downstream MAC accumulator. Finally it hands the finished output word to the write-back stage with a valid/ready handshake. It sits between the layer-level top FSM (start/done) and the address generator / MAC / output buffer datapath.

## Interface
- IMG_W, 48, feature-map row length in words; also the generator's row stride
- IMG_H, 48, feature-map row count
- K, 3, kernel side; window is K*K cycles
- MAC_LAT, 2, cycles from generator address to product valid at accumulator input (memory read + multiply)
- ADDR_B_W, 13, image address width
- ADDR_A_W, 4, kernel address width
- OUT_W, 12, output index width; must hold (IMG_W-K+1)*(IMG_H-K+1)-1

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a layer pass; sampled only in IDLE
- img_base  in  ADDR_B_W  image base address; captured on accepted start
- kern_base  in  ADDR_A_W  kernel base address; captured on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the pass completes
- win_en  out  1  enable to window address generator
- base_addrA  out  ADDR_A_W  kernel base to generator; held for whole pass
- base_addrB  out  ADDR_B_W  window top-left address to generator
- acc_clr  out  1  clears accumulator for a new window
- acc_en  out  1  accumulator add enable; win_en delayed MAC_LAT cycles
- out_valid  out  1  output word ready for write-back
- out_ready  in  1  write-back accepts the word
- out_addr  out  OUT_W  raster index of current output position

## Operation
- States: IDLE, LOAD, FETCH, DRAIN, WRITE, DONE.
- IDLE: all control outputs low. On start=1, capture img_base and kern_base, clear row/col/out_addr, and go to LOAD.
- LOAD (1 cycle): base_addrB = img_base + row*IMG_W + col, computed mod 2^ADDR_B_W. acc_clr=1 and win_en=0 so the generator reloads its bases. Next state is FETCH.
- FETCH (K*K cycles): win_en=1 and the tap counter runs 0..K*K-1. After the last tap, go to DRAIN.
- DRAIN (MAC_LAT cycles): win_en=0. acc_en continues as the delayed copy of win_en. Next state is WRITE.
- WRITE: out_valid=1, out_addr stable. Stay here while out_ready=0. On out_valid and out_ready in the same cycle:
  - If this is the last position (row=IMG_H-K, col=IMG_W-K), go to DONE.
  - Else advance col. At col=IMG_W-K, wrap col to 0 and increment row. Increment out_addr. Go to LOAD.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE.
- acc_en comes from a MAC_LAT-deep shift register fed by win_en. The register is cleared by rst and in IDLE.
- base_addrA = captured kern_base during busy, and 0 in IDLE.
- base_addrB holds its value from LOAD through WRITE.
- start while busy is ignored. Inputs img_base and kern_base may change mid-pass without effect.
- rst at any cycle (mid-FETCH, mid-WRITE, etc.) returns to IDLE next edge. All outputs go to 0 and the shift register and counters clear; no done pulse is produced.

## Timing
- Reset values: busy, done, win_en, acc_clr, acc_en, and out_valid are 0. base_addrA, base_addrB, and out_addr are 0.
- Start sampled at edge t0. LOAD occupies cycle t0+1. FETCH occupies t0+2..t0+1+K*K. DRAIN is MAC_LAT cycles. WRITE starts at t0+2+K*K+MAC_LAT.
- Per-window cost with out_ready held high is 1+K*K+MAC_LAT+1 cycles, which is 13 at the defaults.
- acc_en is high for exactly K*K consecutive cycles per window. It ends on the last DRAIN cycle.
- out_valid rises with WRITE entry and drops on the cycle after handshake. out_addr never changes while out_valid=1 and out_ready=0.
- done asserts the cycle after the final handshake. start may be re-accepted the cycle after DONE.
- Full pass at defaults with out_ready=1 is 46*46*13 = 27508 cycles from start to the final handshake.

## Test plan
- IMG_W=5, IMG_H=4, img_base=100, kern_base=2, out_ready=1:
  - base_addrB sequence is 100,101,102,105,106,107.
  - out_addr runs 0..5.
  - done pulses once, 6*13+1 cycles after start.
- Single window with defaults: win_en high for exactly 9 cycles starting 2 cycles after start; acc_en is the same pulse shifted by 2; acc_clr is high only in LOAD.
- Backpressure: hold out_ready=0 for 5 cycles in the first WRITE. Required response:
  - out_valid stays high with out_addr=0.
  - No LOAD occurs.
  - The next base_addrB is issued the cycle after out_ready rises.
- start pulsed again mid-FETCH: ignored; the sequence and total cycle count are unchanged.
- rst asserted during the 4th FETCH cycle of window 3:
  - Next cycle all outputs are 0 and the state is IDLE, with no done pulse.
  - A fresh start restarts at out_addr=0.
- Wrap: img_base=8190 with IMG_W=5 and IMG_H=3. base_addrB wraps mod 8192 to 8190,8191,0 for row 0; no other output is affected.

Source files
------------

// File: rtl/conv_window_sched.sv
// Layer-pass sequencer for a KxK convolution: walks output positions in raster order,
// drives the window address generator, gates the MAC accumulator and hands each result to write-back.
module conv_window_sched #(
   parameter int IMG_W    = 48,
   parameter int IMG_H    = 48,
   parameter int K        = 3,
   parameter int MAC_LAT  = 2,
   parameter int ADDR_B_W = 13,
   parameter int ADDR_A_W = 4,
   parameter int OUT_W    = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_B_W-1:0] img_base,
   input  logic [ADDR_A_W-1:0] kern_base,
   output logic                busy,
   output logic                done,
   output logic                win_en,
   output logic [ADDR_A_W-1:0] base_addrA,
   output logic [ADDR_B_W-1:0] base_addrB,
   output logic                acc_clr,
   output logic                acc_en,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_W-1:0]    out_addr
);

   localparam int TAPS  = K * K;
   localparam int TAP_W = $clog2(TAPS + 1);
   localparam int DRN_W = $clog2(MAC_LAT + 1);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   localparam logic [TAP_W-1:0]    TAP_LAST   = TAP_W'(TAPS - 1);
   localparam logic [DRN_W-1:0]    DRAIN_LAST = DRN_W'(MAC_LAT - 1);
   localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(IMG_W - K);
   localparam logic [ROW_W-1:0]    ROW_LAST   = ROW_W'(IMG_H - K);
   localparam logic [ADDR_B_W-1:0] WRAP_STEP  = ADDR_B_W'(K);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FETCH = 3'd2,
      S_DRAIN = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [TAP_W-1:0]   tap_r;
   logic [DRN_W-1:0]   drain_r;
   logic [COL_W-1:0]   col_r;
   logic [ROW_W-1:0]   row_r;
   logic [MAC_LAT-1:0] acc_pipe_r;
   logic               last_pos_s;
   logic               accept_s;

   // Next-state decode and write-back handshake detection.
   always_comb begin
      state_nxt_s = state_r;
      last_pos_s  = (row_r == ROW_LAST) && (col_r == COL_LAST);
      accept_s    = (state_r == S_WRITE) && out_ready;
      case (state_r)
         S_IDLE: begin
            if (start) state_nxt_s = S_LOAD;
            else       state_nxt_s = S_IDLE;
         end
         S_LOAD:  state_nxt_s = S_FETCH;
         S_FETCH: begin
            if (tap_r == TAP_LAST) state_nxt_s = S_DRAIN;
            else                   state_nxt_s = S_FETCH;
         end
         S_DRAIN: begin
            if (drain_r == DRAIN_LAST) state_nxt_s = S_WRITE;
            else                       state_nxt_s = S_DRAIN;
         end
         S_WRITE: begin
            if (accept_s) begin
               if (last_pos_s) state_nxt_s = S_DONE;
               else            state_nxt_s = S_LOAD;
            end else begin
               state_nxt_s = S_WRITE;
            end
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= S_IDLE;
      else     state_r <= state_nxt_s;
   end

   // Tap and drain counters run only inside their phase and rest at zero otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         tap_r   <= '0;
         drain_r <= '0;
      end else begin
         tap_r   <= (state_r == S_FETCH) ? tap_r + TAP_W'(1) : '0;
         drain_r <= (state_r == S_DRAIN) ? drain_r + DRN_W'(1) : '0;
      end
   end

   // Position tracking; the window address is stepped incrementally, +K on a row wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_r      <= '0;
         col_r      <= '0;
         out_addr   <= '0;
         base_addrA <= '0;
         base_addrB <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               row_r    <= '0;
               col_r    <= '0;
               out_addr <= '0;
               if (start) begin
                  base_addrA <= kern_base;
                  base_addrB <= img_base;
               end else begin
                  base_addrA <= '0;
                  base_addrB <= '0;
               end
            end
            S_WRITE: begin
               if (accept_s && !last_pos_s) begin
                  out_addr <= out_addr + OUT_W'(1);
                  if (col_r == COL_LAST) begin
                     col_r      <= '0;
                     row_r      <= row_r + ROW_W'(1);
                     base_addrB <= base_addrB + WRAP_STEP;
                  end else begin
                     col_r      <= col_r + COL_W'(1);
                     base_addrB <= base_addrB + ADDR_B_W'(1);
                  end
               end
            end
            S_DONE: begin
               row_r      <= '0;
               col_r      <= '0;
               out_addr   <= '0;
               base_addrA <= '0;
               base_addrB <= '0;
            end
            default: begin
               row_r <= row_r;
            end
         endcase
      end
   end

   // Control strobes are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         win_en    <= 1'b0;
         acc_clr   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         busy      <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
         done      <= (state_nxt_s == S_DONE);
         win_en    <= (state_nxt_s == S_FETCH);
         acc_clr   <= (state_nxt_s == S_LOAD);
         out_valid <= (state_nxt_s == S_WRITE);
      end
   end

   // MAC-latency delay line from win_en to acc_en.
   always_ff @(posedge clk) begin
      if (rst || (state_r == S_IDLE)) begin
         acc_pipe_r <= '0;
      end else begin
         acc_pipe_r[0] <= win_en;
         for (int i = 1; i < MAC_LAT; i++) begin
            acc_pipe_r[i] <= acc_pipe_r[i-1];
         end
      end
   end

   assign acc_en = acc_pipe_r[MAC_LAT-1];

endmodule
